// File: rtl/rvc_asap_dmem_resp_if.sv
// Core <-> data-memory bus for the rvc_asap D_MEM port.
// The core (master) drives address, controls and store data; the memory
// responder (slave) returns combinational, already-aligned load data.
interface rvc_asap_dmem_resp_if;
    logic [31:0] Address;
    logic [31:0] WrData;
    logic [3:0]  ByteEn;
    logic        WrEn;
    logic        RdEn;
    logic        SignExt;
    logic [31:0] RdData;

    modport master (
        output Address, WrData, ByteEn, WrEn, RdEn, SignExt,
        input  RdData
    );

    modport slave (
        input  Address, WrData, ByteEn, WrEn, RdEn, SignExt,
        output RdData
    );
endinterface

// File: rtl/rvc_asap_dmem_resp.sv
// Data-memory responder for the single-cycle rvc_asap core.
// Byte-addressable RAM with async read / clocked byte-masked write, lane
// alignment of the core's unshifted size mask, and a 16-byte MMIO window
// (64-bit cycle counter, scratch register, sticky end-of-test flag).
// Optional: define RVC_DMEM_MISALIGN_CHK_EN to suppress misaligned accesses
// and raise the sticky MisalignErr flag; otherwise MisalignErr is tied low.
module rvc_asap_dmem_resp #(
    parameter int unsigned DMEM_ADRS_W = 12,
    parameter logic [31:0] DMEM_BASE   = 32'h0000_0000,
    parameter logic [31:0] MMIO_BASE   = 32'h00FF_0000
) (
    input  logic                       Clock,
    input  logic                       Rst,
    rvc_asap_dmem_resp_if.slave        dmemBus,
    output logic                       Eot,
    output logic                       MisalignErr
);

    localparam int unsigned RAM_WORDS = 2 ** (DMEM_ADRS_W - 2);
    localparam logic [32:0] RAM_END   = {1'b0, DMEM_BASE} + (33'd1 << DMEM_ADRS_W);

    logic [31:0] ram [0:RAM_WORDS-1];
    logic [63:0] cycleCnt;
    logic [31:0] scratch;

    logic [1:0]             shift;
    logic [DMEM_ADRS_W-3:0] ramIdx;
    logic                   ramHit;
    logic                   mmioHit;
    logic                   accessMisaligned;
    logic                   wrAllowed;
    logic [3:0]             wrMask;
    logic [31:0]            wrWord;
    logic [31:0]            rdWord;
    logic [31:0]            rdShifted;
    logic [31:0]            laneMask;
    logic [31:0]            rdValue;

    assign shift   = dmemBus.Address[1:0];
    assign ramIdx  = dmemBus.Address[DMEM_ADRS_W-1:2];
    assign ramHit  = (dmemBus.Address >= DMEM_BASE) && ({1'b0, dmemBus.Address} < RAM_END);
    assign mmioHit = (dmemBus.Address[31:4] == MMIO_BASE[31:4]);

    // Lanes pushed past byte 3 fall off the top; nothing wraps into the next word.
    assign wrMask = dmemBus.ByteEn << shift;
    assign wrWord = dmemBus.WrData << {shift, 3'b000};

`ifdef RVC_DMEM_MISALIGN_CHK_EN
    assign accessMisaligned = (dmemBus.WrEn || dmemBus.RdEn) &&
                              (((dmemBus.ByteEn == 4'b0011) && dmemBus.Address[0]) ||
                               ((dmemBus.ByteEn == 4'b1111) && (dmemBus.Address[1:0] != 2'b00)));

    // Sticky misalignment flag, cleared only by reset.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            MisalignErr <= 1'b0;
        end else if (accessMisaligned) begin
            MisalignErr <= 1'b1;
        end
    end
`else
    assign accessMisaligned = 1'b0;
    assign MisalignErr      = 1'b0;
`endif

    assign wrAllowed = dmemBus.WrEn && !accessMisaligned;

    // Byte-masked RAM store; a store coinciding with an active Rst is dropped.
    // NOTE: the RAM array has no reset so it maps onto plain memory macros;
    // only the control registers below are cleared.
    always_ff @(posedge Clock) begin
        if (!Rst && wrAllowed && ramHit) begin
            for (int b = 0; b < 4; b++) begin
                if (wrMask[b]) begin
                    ram[ramIdx][8*b +: 8] <= wrWord[8*b +: 8];
                end
            end
        end
    end

    // MMIO state: free-running cycle counter, scratch register, sticky EOT.
    // NOTE: all clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, e.g. a CYCLE read sees the old count.
    always_ff @(posedge Clock or posedge Rst) begin
        if (Rst) begin
            cycleCnt <= '0;
            scratch  <= '0;
            Eot      <= 1'b0;
        end else begin
            cycleCnt <= cycleCnt + 64'd1;
            if (wrAllowed && mmioHit && (dmemBus.Address[3:2] == 2'd2)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wrMask[b]) begin
                        scratch[8*b +: 8] <= wrWord[8*b +: 8];
                    end
                end
            end
            if (wrAllowed && mmioHit && (dmemBus.Address[3:2] == 2'd3) &&
                (dmemBus.WrData != 32'd0)) begin
                Eot <= 1'b1;
            end
        end
    end

    // Combinational load path: select word, right-align, mask, extend.
    // NOTE: every variable gets a default before the branches, so no latch
    // is inferred when a decode or size case is not matched.
    always_comb begin
        rdWord = '0;
        if (ramHit) begin
            rdWord = ram[ramIdx];
        end else if (mmioHit) begin
            case (dmemBus.Address[3:2])
                2'd0:    rdWord = cycleCnt[31:0];
                2'd1:    rdWord = cycleCnt[63:32];
                2'd2:    rdWord = scratch;
                default: rdWord = {31'd0, Eot};
            endcase
        end

        rdShifted = rdWord >> {shift, 3'b000};
        laneMask  = {{8{dmemBus.ByteEn[3]}}, {8{dmemBus.ByteEn[2]}},
                     {8{dmemBus.ByteEn[1]}}, {8{dmemBus.ByteEn[0]}}};
        rdValue   = rdShifted & laneMask;

        if (dmemBus.SignExt) begin
            case (dmemBus.ByteEn)
                4'b0001: rdValue[31:8]  = {24{rdShifted[7]}};
                4'b0011: rdValue[31:16] = {16{rdShifted[15]}};
                default: ;
            endcase
        end
    end

    assign dmemBus.RdData = (dmemBus.RdEn && !accessMisaligned) ? rdValue : 32'd0;

endmodule

// File: tb/tb_rvc_asap_dmem_resp.sv
// Self-checking bench for rvc_asap_dmem_resp: directed scenarios plus
// randomized RAM traffic compared against a byte-array reference model.
module tb_rvc_asap_dmem_resp;

    localparam logic [31:0] MMIO = 32'h00FF_0000;
`ifdef RVC_DMEM_MISALIGN_CHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic Clock = 1'b0;
    logic Rst   = 1'b1;
    logic Eot;
    logic MisalignErr;

    int nCompared   = 0;
    int nMismatched = 0;

    logic [7:0] refMem [0:4095];

    rvc_asap_dmem_resp_if dmemBus();

    rvc_asap_dmem_resp dut (
        .Clock      (Clock),
        .Rst        (Rst),
        .dmemBus    (dmemBus),
        .Eot        (Eot),
        .MisalignErr(MisalignErr)
    );

    always #5 Clock = ~Clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idleBus();
        dmemBus.Address = '0;
        dmemBus.WrData  = '0;
        dmemBus.ByteEn  = 4'b1111;
        dmemBus.WrEn    = 1'b0;
        dmemBus.RdEn    = 1'b0;
        dmemBus.SignExt = 1'b0;
    endtask

    // One bus cycle: drive at the falling edge, sample the async read 1ns later.
    // Any write takes effect at the following rising edge.
    task automatic doCycle(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                           input logic we, input logic re, input logic se,
                           output logic [31:0] rd);
        @(negedge Clock);
        dmemBus.Address = a;
        dmemBus.WrData  = wd;
        dmemBus.ByteEn  = be;
        dmemBus.WrEn    = we;
        dmemBus.RdEn    = re;
        dmemBus.SignExt = se;
        #1;
        rd = dmemBus.RdData;
    endtask

    function automatic int sizeOf(input logic [3:0] be);
        return (be == 4'b0001) ? 1 : (be == 4'b0011) ? 2 : 4;
    endfunction

    function automatic bit isMisaligned(input logic [31:0] a, input logic [3:0] be);
        return CHK_EN && (((be == 4'b0011) && a[0]) || ((be == 4'b1111) && (a[1:0] != 2'b00)));
    endfunction

    // Reference load: gather the bytes that stay inside the word, then extend.
    function automatic logic [31:0] refRead(input logic [31:0] a, input logic [3:0] be, input bit se);
        int n = sizeOf(be);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++)
            if (int'(a[1:0]) + i < 4) v[8*i +: 8] = refMem[int'(a[11:0]) + i];
        if (se && n == 1 && v[7])  v[31:8]  = '1;
        if (se && n == 2 && v[15]) v[31:16] = '1;
        return v;
    endfunction

    task automatic refWrite(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        int n = sizeOf(be);
        for (int i = 0; i < n; i++)
            if (int'(a[1:0]) + i < 4) refMem[int'(a[11:0]) + i] = wd[8*i +: 8];
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        idleBus();
        Rst = 1'b1;
        repeat (3) @(posedge Clock);
        nCompared++; if (Eot !== 1'b0) begin nMismatched++; $display("FAIL reset_eot: got %b want 0", Eot); end
        nCompared++; if (MisalignErr !== 1'b0) begin nMismatched++; $display("FAIL reset_misalign: got %b want 0", MisalignErr); end
        doCycle(MMIO + 32'h8, 32'h0, 4'b1111, 1'b0, 1'b0, 1'b0, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL reset_rden0: got %h want 0", rd); end
        doCycle(MMIO + 32'h8, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL reset_scratch: got %h want 0", rd); end
        doCycle(MMIO + 32'h0, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL reset_cycle: got %h want 0", rd); end
        @(negedge Clock);
        idleBus();
        Rst = 1'b0;
    endtask

    task automatic test_word_byte_half();
        logic [31:0] rd;
        doCycle(32'h10, 32'hDEADBEEF, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        doCycle(32'h10, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'hDEADBEEF) begin nMismatched++; $display("FAIL word_load: got %h want DEADBEEF", rd); end
        doCycle(32'h13, 32'h0, 4'b0001, 1'b0, 1'b1, 1'b1, rd);
        nCompared++; if (rd !== 32'hFFFFFFDE) begin nMismatched++; $display("FAIL byte_sext: got %h want FFFFFFDE", rd); end
        doCycle(32'h13, 32'h0, 4'b0001, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h000000DE) begin nMismatched++; $display("FAIL byte_zext: got %h want 000000DE", rd); end
        doCycle(32'h12, 32'h1234, 4'b0011, 1'b1, 1'b0, 1'b0, rd);
        doCycle(32'h10, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h1234BEEF) begin nMismatched++; $display("FAIL half_store: got %h want 1234BEEF", rd); end
        doCycle(32'h10, 32'h0, 4'b0011, 1'b0, 1'b1, 1'b1, rd);
        nCompared++; if (rd !== 32'hFFFFBEEF) begin nMismatched++; $display("FAIL half_sext: got %h want FFFFBEEF", rd); end
        doCycle(32'h10, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b1, rd);
        nCompared++; if (rd !== 32'h1234BEEF) begin nMismatched++; $display("FAIL word_ignores_sext: got %h want 1234BEEF", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        doCycle(32'h30, 32'hAAAA5555, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        doCycle(32'h30, 32'h0BADF00D, 4'b1111, 1'b1, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'hAAAA5555) begin nMismatched++; $display("FAIL rw_same_cycle_old: got %h want AAAA5555", rd); end
        doCycle(32'h30, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h0BADF00D) begin nMismatched++; $display("FAIL rw_next_cycle_new: got %h want 0BADF00D", rd); end
    endtask

    task automatic test_counter();
        logic [31:0] rd;
        @(negedge Clock); idleBus(); Rst = 1'b1;
        @(negedge Clock); Rst = 1'b0;
        repeat (100) @(posedge Clock);
        doCycle(MMIO + 32'h0, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'd100) begin nMismatched++; $display("FAIL cycle_lo: got %0d want 100", rd); end
        doCycle(MMIO + 32'h4, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'd0) begin nMismatched++; $display("FAIL cycle_hi: got %0d want 0", rd); end
        doCycle(MMIO + 32'h0, 32'hFFFFFFFF, 4'b1111, 1'b1, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'd102) begin nMismatched++; $display("FAIL cycle_wr_read: got %0d want 102", rd); end
        doCycle(MMIO + 32'h0, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'd103) begin nMismatched++; $display("FAIL cycle_ro: got %0d want 103", rd); end
    endtask

    task automatic test_unmapped();
        logic [31:0] rd;
        doCycle(32'h1010, 32'h77777777, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        doCycle(32'h1010, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL unmapped_read: got %h want 0", rd); end
        doCycle(32'h10, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h1234BEEF) begin nMismatched++; $display("FAIL unmapped_no_alias: got %h want 1234BEEF", rd); end
        doCycle(MMIO + 32'h10, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL past_mmio_read: got %h want 0", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd;
        logic [31:0] expWord;
        logic [31:0] expRead;
        expWord = CHK_EN ? 32'h11223344 : 32'hBBCCDD44;
        expRead = CHK_EN ? 32'h0 : 32'h0000BBCC;
        doCycle(32'h20, 32'h11223344, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        doCycle(32'h21, 32'hAABBCCDD, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        nCompared++; if (MisalignErr !== 1'b0) begin nMismatched++; $display("FAIL misalign_before_edge: got %b want 0", MisalignErr); end
        doCycle(32'h20, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== expWord) begin nMismatched++; $display("FAIL misalign_store: got %h want %h", rd, expWord); end
        nCompared++; if (MisalignErr !== CHK_EN) begin nMismatched++; $display("FAIL misalign_flag: got %b want %b", MisalignErr, CHK_EN); end
        doCycle(32'h22, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== expRead) begin nMismatched++; $display("FAIL misalign_load: got %h want %h", rd, expRead); end
    endtask

    task automatic test_eot_reset();
        logic [31:0] rd;
        doCycle(32'h40, 32'h12345678, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        doCycle(MMIO + 32'hC, 32'h0, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        doCycle(MMIO + 32'hC, 32'h1, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        nCompared++; if (Eot !== 1'b0) begin nMismatched++; $display("FAIL eot_zero_write: got %b want 0", Eot); end
        doCycle(MMIO + 32'hC, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (Eot !== 1'b1) begin nMismatched++; $display("FAIL eot_set: got %b want 1", Eot); end
        nCompared++; if (rd !== 32'h1) begin nMismatched++; $display("FAIL eot_read: got %h want 1", rd); end
        doCycle(MMIO + 32'h8, 32'hA5A5A5A5, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        doCycle(MMIO + 32'h9, 32'h3C, 4'b0001, 1'b1, 1'b0, 1'b0, rd);
        doCycle(MMIO + 32'h8, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'hA5A53CA5) begin nMismatched++; $display("FAIL scratch_rw: got %h want A5A53CA5", rd); end
        nCompared++; if (Eot !== 1'b1) begin nMismatched++; $display("FAIL eot_sticky: got %b want 1", Eot); end
        // Assert reset asynchronously, mid-cycle.
        @(posedge Clock); #2;
        Rst = 1'b1;
        #1;
        nCompared++; if (Eot !== 1'b0) begin nMismatched++; $display("FAIL async_rst_eot: got %b want 0", Eot); end
        nCompared++; if (MisalignErr !== 1'b0) begin nMismatched++; $display("FAIL async_rst_misalign: got %b want 0", MisalignErr); end
        doCycle(MMIO + 32'h8, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL async_rst_scratch: got %h want 0", rd); end
        doCycle(MMIO + 32'h0, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h0) begin nMismatched++; $display("FAIL async_rst_cycle: got %h want 0", rd); end
        doCycle(32'h40, 32'h00000055, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
        @(negedge Clock);
        idleBus();
        Rst = 1'b0;
        doCycle(32'h40, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
        nCompared++; if (rd !== 32'h12345678) begin nMismatched++; $display("FAIL rst_write_discard: got %h want 12345678", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] exp;
        logic [3:0]  be;
        logic        we;
        logic        re;
        logic        se;
        bit          anyMisal = 1'b0;
        int          kind;
        // Seed a 256-byte region so every later load reads defined data.
        for (int w = 0; w < 64; w++) begin
            a  = 32'h200 + 32'(4 * w);
            wd = $urandom;
            doCycle(a, wd, 4'b1111, 1'b1, 1'b0, 1'b0, rd);
            refWrite(a, 4'b1111, wd);
        end
        for (int t = 0; t < 300; t++) begin
            kind = $urandom_range(0, 2);
            we = (kind != 1);
            re = (kind != 0);
            case ($urandom_range(0, 2))
                0:       be = 4'b0001;
                1:       be = 4'b0011;
                default: be = 4'b1111;
            endcase
            a  = 32'h200 + 32'($urandom_range(0, 255));
            wd = $urandom;
            se = 1'($urandom_range(0, 1));
            exp = (re && !isMisaligned(a, be)) ? refRead(a, be, se) : 32'h0;
            doCycle(a, wd, be, we, re, se, rd);
            nCompared++;
            if (rd !== exp) begin
                nMismatched++;
                $display("FAIL rand_op%0d addr=%h be=%b we=%b se=%b: got %h want %h", t, a, be, we, se, rd, exp);
            end
            if (isMisaligned(a, be)) anyMisal = 1'b1;
            else if (we) refWrite(a, be, wd);
        end
        for (int w = 0; w < 64; w++) begin
            a = 32'h200 + 32'(4 * w);
            exp = refRead(a, 4'b1111, 1'b0);
            doCycle(a, 32'h0, 4'b1111, 1'b0, 1'b1, 1'b0, rd);
            nCompared++;
            if (rd !== exp) begin
                nMismatched++;
                $display("FAIL rand_final_word addr=%h: got %h want %h", a, rd, exp);
            end
        end
        nCompared++;
        if (MisalignErr !== anyMisal) begin
            nMismatched++;
            $display("FAIL rand_misalign_flag: got %b want %b", MisalignErr, anyMisal);
        end
        @(negedge Clock);
        idleBus();
    endtask

    initial begin
        idleBus();
        test_reset();
        test_word_byte_half();
        test_back_to_back();
        test_counter();
        test_unmapped();
        test_misalign();
        test_eot_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
